// File: rtl/tm1638_key_events_if.sv
`default_nettype none
// ------------------------------------------------------------------
// tm1638_key_events_if : key event valid/ready handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
interface tm1638_key_events_if #(
  parameter int W_KEY = 8
) ();
  localparam int KEY_W = (W_KEY > 1) ? $clog2(W_KEY) : 1;

  logic             ev_valid;
  logic             ev_ready;
  logic [KEY_W-1:0] ev_key;
  logic             ev_press;

  modport master (output ev_valid, output ev_key, output ev_press, input ev_ready);
  modport slave  (input ev_valid, input ev_key, input ev_press, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/tm1638_key_events.sv
`default_nettype none
// ------------------------------------------------------------------
// tm1638_key_events : TM1638 key debounce and press/release event FIFO
// Rev 1.0
// ------------------------------------------------------------------
module tm1638_key_events #(
  parameter int W_KEY           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  wire              clk,
  input  wire              rst,
  input  wire  [W_KEY-1:0] keys_raw,
  output logic [W_KEY-1:0] pressed,
  output logic             ovf,
  input  wire              ovf_clr,
  tm1638_key_events_if.master ev
);
  localparam int KEY_W  = (W_KEY > 1) ? $clog2(W_KEY) : 1;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W_KEY-1:0]      r_keys_q;
  logic [W_KEY-1:0]      r_samp;
  logic [W_KEY-1:0]      r_pressed;
  logic [W_KEY-1:0]      r_pending;
  logic [CNT_W-1:0]      r_tick_cnt;
  logic                  r_ovf;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [KEY_W-1:0]      r_mem_key [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_press;

  logic                  w_tick;
  logic [W_KEY-1:0]      w_flip;
  logic [KEY_W-1:0]      w_sel;
  logic                  w_any;
  logic [W_KEY-1:0]      w_clear;
  logic                  w_overrun;
  logic [PTR_W-1:0]      w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic [ADDR_W-1:0]     w_wr_addr;
  logic [ADDR_W-1:0]     w_rd_addr;

  assign w_tick = (r_tick_cnt == c_tick_last);

  // A key flips only when two consecutive tick samples agree and differ from the held state.
  assign w_flip = w_tick ? (~(r_keys_q ^ r_samp) & (r_keys_q ^ r_pressed)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_keys_q   <= '0;
      r_samp     <= '0;
      r_pressed  <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_keys_q   <= keys_raw;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        r_samp    <= r_keys_q;
        r_pressed <= r_pressed ^ w_flip;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = W_KEY - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_sel = KEY_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == PTR_W'(FIFO_DEPTH));
  assign w_empty   = (w_count == '0);
  assign w_pop     = !w_empty && ev.ev_ready;
  assign w_push    = w_any && (!w_full || w_pop);
  assign w_wr_addr = r_wr_ptr[ADDR_W-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_W-1:0];
  assign w_clear   = w_push ? (W_KEY'(1) << w_sel) : '0;

  // A fresh flip on a key that is being pushed this cycle is not a loss.
  assign w_overrun = |(w_flip & r_pending & ~w_clear);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_flip;
      if (w_overrun) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_key[w_wr_addr]   <= w_sel;
      r_mem_press[w_wr_addr] <= r_pressed[w_sel];
    end
  end

  assign pressed     = r_pressed;
  assign ovf         = r_ovf;
  assign ev.ev_valid = !w_empty;
  assign ev.ev_key   = w_empty ? '0 : r_mem_key[w_rd_addr];
  assign ev.ev_press = w_empty ? 1'b0 : r_mem_press[w_rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_tm1638_key_events.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tm1638_key_events : directed bench for the key event queue
// Rev 1.0
// ------------------------------------------------------------------
module tb_tm1638_key_events;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] keys_raw = 8'h00;
  logic [7:0] pressed;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  tm1638_key_events_if #(.W_KEY(8)) kif ();

  tm1638_key_events #(
    .W_KEY(8),
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keys_raw(keys_raw),
    .pressed(pressed),
    .ovf(ovf),
    .ovf_clr(ovf_clr),
    .ev(kif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] key;
    logic       press;
    int         cyc;
  } ev_t;

  ev_t evq[$];
  ev_t mon_ev;
  int  cyc_cnt      = 0;
  int  tests_run    = 0;
  int  tests_failed = 0;

  // Accepted events are logged at the falling edge, before the popping rising edge.
  always @(negedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (rst === 1'b0 && kif.ev_valid === 1'b1 && kif.ev_ready === 1'b1) begin
      mon_ev.key   = kif.ev_key;
      mon_ev.press = kif.ev_press;
      mon_ev.cyc   = cyc_cnt;
      evq.push_back(mon_ev);
    end
  end

  initial begin
    kif.ev_ready = 1'b0;
  end

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) next_drive();
  endtask

  task automatic wait_pressed(input logic [7:0] target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (pressed === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_all();
    bit ok;
    keys_raw     = 8'h00;
    kif.ev_ready = 1'b1;
    wait_pressed(8'h00, 12, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL release_all: pressed=%h required 00", pressed);
    end
    next_drive();
    run(10);
    evq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pressed !== 8'h00) begin tests_failed++; $display("FAIL reset_pressed: got %h required 00", pressed); end
    tests_run++;
    if (kif.ev_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ev_valid: got %b required 0", kif.ev_valid); end
    tests_run++;
    if (kif.ev_key !== 3'd0) begin tests_failed++; $display("FAIL reset_ev_key: got %0d required 0", kif.ev_key); end
    tests_run++;
    if (kif.ev_press !== 1'b0) begin tests_failed++; $display("FAIL reset_ev_press: got %b required 0", kif.ev_press); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b required 0", ovf); end
    next_drive();
    evq.delete();
  endtask

  task automatic test_press_release();
    bit ok;
    evq.delete();
    kif.ev_ready = 1'b1;
    keys_raw     = 8'h04;
    wait_pressed(8'h04, 10, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL press_latency: pressed=%h required 04 within 10 cycles", pressed); end
    next_drive();
    run(15);
    tests_run++;
    if (evq.size() != 1) begin
      tests_failed++;
      $display("FAIL press_count: got %0d events required 1", evq.size());
    end else begin
      tests_run++;
      if (evq[0].key !== 3'd2 || evq[0].press !== 1'b1) begin
        tests_failed++;
        $display("FAIL press_event: got key=%0d press=%b required key=2 press=1", evq[0].key, evq[0].press);
      end
    end

    evq.delete();
    keys_raw = 8'h00;
    wait_pressed(8'h00, 10, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL release_latency: pressed=%h required 00", pressed); end
    next_drive();
    run(10);
    tests_run++;
    if (evq.size() != 1) begin
      tests_failed++;
      $display("FAIL release_count: got %0d events required 1", evq.size());
    end else begin
      tests_run++;
      if (evq[0].key !== 3'd2 || evq[0].press !== 1'b0) begin
        tests_failed++;
        $display("FAIL release_event: got key=%0d press=%b required key=2 press=0", evq[0].key, evq[0].press);
      end
    end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL release_ovf: got %b required 0", ovf); end
    evq.delete();
  endtask

  task automatic test_glitch();
    bit seen;
    seen = 1'b0;
    evq.delete();
    run(3);
    keys_raw = 8'h20;
    next_drive();
    next_drive();
    keys_raw = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pressed !== 8'h00) seen = 1'b1;
    end
    next_drive();
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL glitch_pressed: pressed changed, final=%h required 00", pressed); end
    tests_run++;
    if (evq.size() != 0) begin tests_failed++; $display("FAIL glitch_events: got %0d events required 0", evq.size()); end
  endtask

  task automatic test_simultaneous();
    bit         ok;
    logic [2:0] exp_keys [3];
    exp_keys[0] = 3'd0;
    exp_keys[1] = 3'd4;
    exp_keys[2] = 3'd7;
    evq.delete();
    kif.ev_ready = 1'b1;
    keys_raw     = 8'h91;
    wait_pressed(8'h91, 10, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL simul_pressed: pressed=%h required 91", pressed); end
    next_drive();
    run(10);
    tests_run++;
    if (evq.size() != 3) begin
      tests_failed++;
      $display("FAIL simul_count: got %0d events required 3", evq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (evq[i].key !== exp_keys[i] || evq[i].press !== 1'b1) begin
          tests_failed++;
          $display("FAIL simul_event%0d: got key=%0d press=%b required key=%0d press=1",
                   i, evq[i].key, evq[i].press, exp_keys[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        tests_run++;
        if (evq[i].cyc != evq[i-1].cyc + 1) begin
          tests_failed++;
          $display("FAIL simul_spacing%0d: got gap %0d cycles required 1", i, evq[i].cyc - evq[i-1].cyc);
        end
      end
    end
    release_all();
  endtask

  task automatic test_back_to_back();
    bit ok;
    evq.delete();
    kif.ev_ready = 1'b0;
    keys_raw     = 8'h3F;
    wait_pressed(8'h3F, 10, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_pressed: pressed=%h required 3f", pressed); end
    next_drive();
    run(5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (kif.ev_valid !== 1'b1 || kif.ev_key !== 3'd0 || kif.ev_press !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_head%0d: got valid=%b key=%0d press=%b required valid=1 key=0 press=1",
                 i, kif.ev_valid, kif.ev_key, kif.ev_press);
      end
    end
    next_drive();
    kif.ev_ready = 1'b1;
    run(12);
    tests_run++;
    if (evq.size() != 6) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d events required 6", evq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (evq[i].key !== 3'(i) || evq[i].press !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_event%0d: got key=%0d press=%b required key=%0d press=1",
                   i, evq[i].key, evq[i].press, i);
        end
      end
    end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL bp_ovf: got %b required 0", ovf); end
    release_all();
  endtask

  task automatic test_overrun();
    bit ok;
    evq.delete();
    kif.ev_ready = 1'b0;
    keys_raw     = 8'h4F;
    wait_pressed(8'h4F, 10, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL ovr_press: pressed=%h required 4f", pressed); end
    next_drive();
    keys_raw = 8'h0F;
    wait_pressed(8'h0F, 12, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL ovr_release: pressed=%h required 0f", pressed); end
    next_drive();
    tests_run++;
    if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got %b required 1", ovf); end
    tests_run++;
    if (kif.ev_valid !== 1'b1 || kif.ev_key !== 3'd0) begin
      tests_failed++;
      $display("FAIL ovr_head: got valid=%b key=%0d required valid=1 key=0", kif.ev_valid, kif.ev_key);
    end
    kif.ev_ready = 1'b1;
    run(10);
    tests_run++;
    if (evq.size() != 5) begin
      tests_failed++;
      $display("FAIL ovr_count: got %0d events required 5", evq.size());
    end else begin
      tests_run++;
      if (evq[4].key !== 3'd6 || evq[4].press !== 1'b0) begin
        tests_failed++;
        $display("FAIL ovr_event: got key=%0d press=%b required key=6 press=0", evq[4].key, evq[4].press);
      end
    end
    tests_run++;
    if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b required 1", ovf); end
    ovf_clr = 1'b1;
    next_drive();
    ovf_clr = 1'b0;
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b required 0", ovf); end
    release_all();
  endtask

  task automatic test_reset_midop();
    bit ok;
    evq.delete();
    kif.ev_ready = 1'b0;
    keys_raw     = 8'h07;
    wait_pressed(8'h07, 10, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rmid_pressed: pressed=%h required 07", pressed); end
    next_drive();
    run(5);
    tests_run++;
    if (kif.ev_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_queued: ev_valid=%b required 1", kif.ev_valid); end
    rst = 1'b1;
    next_drive();
    rst = 1'b0;
    tests_run++;
    if (kif.ev_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_ev_valid: got %b required 0", kif.ev_valid); end
    tests_run++;
    if (pressed !== 8'h00) begin tests_failed++; $display("FAIL rmid_pressed_clr: got %h required 00", pressed); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL rmid_ovf: got %b required 0", ovf); end
    evq.delete();
    kif.ev_ready = 1'b1;
    run(25);
    tests_run++;
    if (pressed !== 8'h07) begin tests_failed++; $display("FAIL rmid_repress: pressed=%h required 07", pressed); end
    tests_run++;
    if (evq.size() != 3) begin
      tests_failed++;
      $display("FAIL rmid_count: got %0d events required 3", evq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (evq[i].key !== 3'(i) || evq[i].press !== 1'b1) begin
          tests_failed++;
          $display("FAIL rmid_event%0d: got key=%0d press=%b required key=%0d press=1",
                   i, evq[i].key, evq[i].press, i);
        end
      end
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_overrun();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
